exu_wb_buffer: RTL and testbench



---
 rtl/exu_wb_buffer_if.sv | 42 ++++
 rtl/exu_wb_buffer.sv | 108 ++++++++++
 tb/tb_exu_wb_buffer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/exu_wb_buffer_if.sv
// Execute-to-writeback buffer bus: execute-side capture inputs, writeback-side head outputs.
// slave = buffer, master = execute/writeback driver.
interface exu_wb_buffer_if #(
   parameter int PC_W     = 64,
   parameter int INSTR_W  = 32,
   parameter int LREG_W   = 5,
   parameter int RESULT_W = 64
);
   logic                in_valid;
   logic                in_ready;
   logic [PC_W-1:0]     in_pc;
   logic [INSTR_W-1:0]  in_instr;
   logic [LREG_W-1:0]   in_rd;
   logic                in_need_to_wb;
   logic [2:0]          in_unit_sel;
   logic [RESULT_W-1:0] in_alu_result;
   logic [RESULT_W-1:0] in_bju_result;
   logic [RESULT_W-1:0] in_muldiv_result;
   logic                flush;
   logic                out_valid;
   logic                out_ready;
   logic [PC_W-1:0]     out_pc;
   logic [INSTR_W-1:0]  out_instr;
   logic [LREG_W-1:0]   out_rd;
   logic                out_wb_en;
   logic [RESULT_W-1:0] out_result;
   logic [63:0]         retire_count;

   modport slave (
      input  in_valid, in_pc, in_instr, in_rd, in_need_to_wb, in_unit_sel,
             in_alu_result, in_bju_result, in_muldiv_result, flush, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_rd, out_wb_en,
             out_result, retire_count
   );

   modport master (
      output in_valid, in_pc, in_instr, in_rd, in_need_to_wb, in_unit_sel,
             in_alu_result, in_bju_result, in_muldiv_result, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_rd, out_wb_en,
             out_result, retire_count
   );
endinterface

// File: rtl/exu_wb_buffer.sv
// Two-entry elastic buffer between execute and writeback; selects the writeback
// value at capture time and hands one entry per cycle to writeback.
module exu_wb_buffer #(
   parameter int                   PC_W     = 64,
   parameter int                   INSTR_W  = 32,
   parameter int                   LREG_W   = 5,
   parameter int                   RESULT_W = 64,
   parameter int                   DEPTH    = 2,
   parameter logic [RESULT_W-1:0]  POISON   = 64'hDEADBEEF
) (
   input  logic           clock,
   input  logic           reset_n,
   exu_wb_buffer_if.slave bus
);
   typedef struct packed {
      logic [PC_W-1:0]     pc;
      logic [INSTR_W-1:0]  instr;
      logic [LREG_W-1:0]   rd;
      logic                wb_en;
      logic [RESULT_W-1:0] result;
   } entry_t;

   logic        r_wptr;
   logic        r_rptr;
   logic [1:0]  r_count;
   logic [63:0] r_retire_count;

   logic        w_in_ready;
   logic        w_out_valid;
   logic        w_push;
   logic        w_pop;
   entry_t      w_wr_entry;
   entry_t      w_entries [DEPTH];

   // in_ready depends only on stored occupancy, never on out_ready.
   assign w_in_ready  = (r_count != 2'd2);
   assign w_out_valid = (r_count != 2'd0);
   assign w_push      = bus.in_valid & w_in_ready & ~bus.flush;
   assign w_pop       = w_out_valid & bus.out_ready & ~bus.flush;

   always_comb begin
      w_wr_entry       = '0;
      w_wr_entry.pc    = bus.in_pc;
      w_wr_entry.instr = bus.in_instr;
      w_wr_entry.rd    = bus.in_rd;
      w_wr_entry.wb_en = bus.in_need_to_wb & (|bus.in_unit_sel) & (bus.in_rd != '0);
      // Same priority as the execute bypass: alu, then muldiv, then bju.
      if (bus.in_unit_sel[0])
         w_wr_entry.result = bus.in_alu_result;
      else if (bus.in_unit_sel[2])
         w_wr_entry.result = bus.in_muldiv_result;
      else if (bus.in_unit_sel[1])
         w_wr_entry.result = bus.in_bju_result;
      else
         w_wr_entry.result = POISON;
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         localparam logic LP_IDX = 1'(gi);
         entry_t r_entry;

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
               r_entry <= '0;
            else if (w_push && (r_wptr == LP_IDX))
               r_entry <= w_wr_entry;
         end

         assign w_entries[gi] = r_entry;
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr         <= 1'b0;
         r_rptr         <= 1'b0;
         r_count        <= 2'd0;
         r_retire_count <= 64'd0;
      end else if (bus.flush) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push)
            r_wptr <= ~r_wptr;
         if (w_pop) begin
            r_rptr         <= ~r_rptr;
            r_retire_count <= r_retire_count + 64'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.in_ready     = w_in_ready;
   assign bus.out_valid    = w_out_valid;
   assign bus.out_pc       = w_entries[r_rptr].pc;
   assign bus.out_instr    = w_entries[r_rptr].instr;
   assign bus.out_rd       = w_entries[r_rptr].rd;
   assign bus.out_wb_en    = w_entries[r_rptr].wb_en;
   assign bus.out_result   = w_entries[r_rptr].result;
   assign bus.retire_count = r_retire_count;
endmodule

// File: tb/tb_exu_wb_buffer.sv
// Directed bench for exu_wb_buffer: queue-based reference model checked every
// cycle on the falling edge, plus literal expectations for the key scenarios.
module tb_exu_wb_buffer;
   localparam logic [63:0] POISON_V = 64'hDEADBEEF;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   exu_wb_buffer_if bus ();

   exu_wb_buffer dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic        wb;
      logic [63:0] res;
   } exp_t;

   exp_t        q[$];
   logic [63:0] m_retire = 64'd0;
   int          n_err = 0;
   int          n_chk = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] sel_result(input logic [2:0] sel, input logic [63:0] a,
                                              input logic [63:0] b, input logic [63:0] m);
      if (sel[0]) return a;
      if (sel[2]) return m;
      if (sel[1]) return b;
      return POISON_V;
   endfunction

   // Reference model: a bounded FIFO of at most two entries.
   always @(posedge clk or negedge rst_n) begin
      exp_t e;
      bit   do_push;
      bit   do_pop;
      if (!rst_n) begin
         q.delete();
         m_retire = 64'd0;
      end else if (bus.flush) begin
         q.delete();
      end else begin
         do_push = bus.in_valid && (q.size() < 2);
         do_pop  = (q.size() != 0) && bus.out_ready;
         if (do_pop) begin
            $display("wb  pc=%h rd=%0d wb_en=%0b result=%h", q[0].pc, q[0].rd, q[0].wb, q[0].res);
            void'(q.pop_front());
            m_retire = m_retire + 64'd1;
         end
         if (do_push) begin
            e.pc    = bus.in_pc;
            e.instr = bus.in_instr;
            e.rd    = bus.in_rd;
            e.wb    = bus.in_need_to_wb && (bus.in_unit_sel != 3'b000) && (bus.in_rd != 5'd0);
            e.res   = sel_result(bus.in_unit_sel, bus.in_alu_result, bus.in_bju_result,
                                 bus.in_muldiv_result);
            q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      check("retire_count", bus.retire_count, m_retire);
      if (q.size() != 0) begin
         check("out_pc", bus.out_pc, q[0].pc);
         check("out_instr", 64'(bus.out_instr), 64'(q[0].instr));
         check("out_rd", 64'(bus.out_rd), 64'(q[0].rd));
         check("out_wb_en", 64'(bus.out_wb_en), 64'(q[0].wb));
         check("out_result", bus.out_result, q[0].res);
      end
   end

   task automatic drive(input logic [63:0] pc, input logic [2:0] sel, input logic [4:0] rd,
                        input logic need, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] m);
      bus.in_valid         = 1'b1;
      bus.in_pc            = pc;
      bus.in_instr         = {16'h0013, pc[15:0]};
      bus.in_rd            = rd;
      bus.in_need_to_wb    = need;
      bus.in_unit_sel      = sel;
      bus.in_alu_result    = a;
      bus.in_bju_result    = b;
      bus.in_muldiv_result = m;
   endtask

   task automatic push_check(input string nm, input logic [63:0] pc, input logic [2:0] sel,
                             input logic [4:0] rd, input logic need, input logic [63:0] a,
                             input logic [63:0] b, input logic [63:0] m,
                             input logic [63:0] exp_res, input logic exp_wb);
      bus.out_ready = 1'b1;
      drive(pc, sel, rd, need, a, b, m);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({nm, "_result"}, bus.out_result, exp_res);
      check({nm, "_wb_en"}, 64'(bus.out_wb_en), 64'(exp_wb));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [63:0] base;
      bus.in_valid         = 1'b0;
      bus.in_pc            = '0;
      bus.in_instr         = '0;
      bus.in_rd            = '0;
      bus.in_need_to_wb    = 1'b0;
      bus.in_unit_sel      = 3'b000;
      bus.in_alu_result    = '0;
      bus.in_bju_result    = '0;
      bus.in_muldiv_result = '0;
      bus.flush            = 1'b0;
      bus.out_ready        = 1'b0;

      // Reset state
      #2;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_pc", bus.out_pc, 64'd0);
      check("rst_out_result", bus.out_result, 64'd0);
      check("rst_out_wb_en", 64'(bus.out_wb_en), 64'd0);
      check("rst_retire", bus.retire_count, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single ALU op, then retire count after the pop edge
      push_check("alu", 64'h10, 3'b001, 5'd3, 1'b1, 64'h5, 64'h0, 64'h0, 64'h5, 1'b1);
      check("alu_retire", bus.retire_count, 64'd1);
      check("alu_drained", 64'(bus.out_valid), 64'd0);

      // Priority and poison
      push_check("mul_over_bju", 64'h20, 3'b110, 5'd4, 1'b1, 64'h1, 64'h7, 64'h9, 64'h9, 1'b1);
      push_check("poison", 64'h24, 3'b000, 5'd4, 1'b1, 64'h1, 64'h7, 64'h9, POISON_V, 1'b0);
      push_check("rd_zero", 64'h28, 3'b001, 5'd0, 1'b1, 64'hB, 64'h7, 64'h9, 64'hB, 1'b0);
      push_check("alu_over_bju", 64'h2C, 3'b011, 5'd6, 1'b1, 64'h1, 64'h2, 64'h3, 64'h1, 1'b1);
      push_check("bju_only", 64'h30, 3'b010, 5'd7, 1'b1, 64'h1, 64'h7, 64'h3, 64'h7, 1'b1);
      push_check("no_wb", 64'h34, 3'b100, 5'd8, 1'b0, 64'h1, 64'h7, 64'h3, 64'h3, 1'b0);

      // Backpressure: A, B fill the buffer, C is ignored
      bus.out_ready = 1'b0;
      drive(64'h100, 3'b001, 5'd1, 1'b1, 64'hA, 64'h0, 64'h0);
      @(posedge clk); #1;
      check("bp_ready_after_a", 64'(bus.in_ready), 64'd1);
      drive(64'h104, 3'b001, 5'd2, 1'b1, 64'hB, 64'h0, 64'h0);
      @(posedge clk); #1;
      check("bp_full", 64'(bus.in_ready), 64'd0);
      drive(64'h108, 3'b001, 5'd3, 1'b1, 64'hC, 64'h0, 64'h0);
      @(posedge clk); #1;
      check("bp_hold_pc", bus.out_pc, 64'h100);
      check("bp_still_full", 64'(bus.in_ready), 64'd0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_b_next", bus.out_pc, 64'h104);
      check("bp_ready_back", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      check("bp_c_dropped", 64'(bus.out_valid), 64'd0);

      // Streaming 100 entries back to back
      base = bus.retire_count;
      for (int i = 0; i < 100; i++) begin
         drive(64'(i * 4), 3'b001, 5'd5, 1'b1, 64'(i), 64'h0, 64'h0);
         @(posedge clk); #1;
         check("stream_pc", bus.out_pc, 64'(i * 4));
         check("stream_ready", 64'(bus.in_ready), 64'd1);
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check("stream_retire", bus.retire_count, base + 64'd100);
      check("stream_empty", 64'(bus.out_valid), 64'd0);

      // Flush while full with push and pop requested
      bus.out_ready = 1'b0;
      drive(64'h200, 3'b001, 5'd1, 1'b1, 64'h1, 64'h0, 64'h0);
      @(posedge clk); #1;
      drive(64'h204, 3'b001, 5'd1, 1'b1, 64'h2, 64'h0, 64'h0);
      @(posedge clk); #1;
      base = bus.retire_count;
      drive(64'h208, 3'b001, 5'd1, 1'b1, 64'h3, 64'h0, 64'h0);
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_valid", 64'(bus.out_valid), 64'd0);
      check("flush_ready", 64'(bus.in_ready), 64'd1);
      check("flush_retire", bus.retire_count, base);
      @(posedge clk); #1;

      // Asynchronous reset with one entry held
      bus.out_ready = 1'b0;
      drive(64'h300, 3'b001, 5'd9, 1'b1, 64'h77, 64'h0, 64'h0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("arst_pre_valid", 64'(bus.out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(bus.out_valid), 64'd0);
      check("arst_ready", 64'(bus.in_ready), 64'd1);
      check("arst_pc", bus.out_pc, 64'd0);
      check("arst_result", bus.out_result, 64'd0);
      check("arst_wb_en", 64'(bus.out_wb_en), 64'd0);
      check("arst_retire", bus.retire_count, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      push_check("recover", 64'h400, 3'b100, 5'd2, 1'b1, 64'h1, 64'h2, 64'h33, 64'h33, 1'b1);
      check("recover_retire", bus.retire_count, 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
